jk_reg_counter: RTL and testbench

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK flip-flops sharing one clock.
- Selectable operating modes:
  - per-bit direct JK
  - synchronous up counter
  - synchronous down counter
  - parallel load
- Adds synchronous reset, clock enable and a terminal-count flag.
- Used wherever the lab designs need a JK-based register or counter wider than one bit.

---
 rtl/jk_reg_counter.sv | 115 +++++++++++
 tb/tb_jk_reg_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_counter.sv
// jk_reg_counter: WIDTH-bit bank of JK flip-flops with direct JK, up/down count and parallel load.
// Optional macro JK_SATURATE_EN makes both count modes saturate instead of wrapping.
module jk_reg_counter #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);

    localparam logic [1:0] M_JK   = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic [WIDTH-1:0] up_tgl;
    logic [WIDTH-1:0] dn_tgl;
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [WIDTH-1:0] q_next;
    logic             all_ones;
    logic             all_zero;
    logic             sat_up;
    logic             sat_dn;

    assign all_ones = (q == {WIDTH{1'b1}});
    assign all_zero = (q == {WIDTH{1'b0}});

`ifdef JK_SATURATE_EN
    assign sat_up = all_ones;
    assign sat_dn = all_zero;
`else
    assign sat_up = 1'b0;
    assign sat_dn = 1'b0;
`endif

    // Ripple toggle chains: a bit toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin : toggle_chain
        logic ru;
        logic rd;
        ru = 1'b1;
        rd = 1'b1;
        up_tgl = '0;
        dn_tgl = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_tgl[i] = ru;
            dn_tgl[i] = rd;
            ru = ru & q[i];
            rd = rd & ~q[i];
        end
    end

    // Map the selected mode onto per-bit J/K inputs.
    always_comb begin
        jv = '0;
        kv = '0;
        unique case (mode)
            M_JK: begin
                jv = j;
                kv = k;
            end
            M_UP: begin
                jv = sat_up ? '0 : up_tgl;
                kv = sat_up ? '0 : up_tgl;
            end
            M_DOWN: begin
                jv = sat_dn ? '0 : dn_tgl;
                kv = sat_dn ? '0 : dn_tgl;
            end
            M_LOAD: begin
                jv = d;
                kv = ~d;
            end
            default: begin
                jv = '0;
                kv = '0;
            end
        endcase
    end

    // JK characteristic equation applied bitwise.
    always_comb begin
        q_next = (jv & ~q) | (~kv & q);
    end

    // State register: reset beats enable, enable beats mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= q_next;
        end
    end

    // Terminal count is only meaningful in the two count modes.
    always_comb begin
        tc = 1'b0;
        if (mode == M_UP && all_ones) begin
            tc = 1'b1;
        end else if (mode == M_DOWN && all_zero) begin
            tc = 1'b1;
        end
    end

    assign qb = ~q;

endmodule

// File: tb/tb_jk_reg_counter.sv
// tb_jk_reg_counter: directed scenarios plus randomized traffic against an arithmetic model.
// Honours JK_SATURATE_EN so the same bench covers both builds.
module tb_jk_reg_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;

    localparam logic [3:0] RV = 4'b1010;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] mq;

    jk_reg_counter #(.WIDTH(4), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .j(j), .k(k), .d(d), .q(q), .qb(qb), .tc(tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_next(
        input logic [3:0] cur, input logic r, input logic e,
        input logic [1:0] m, input logic [3:0] jj,
        input logic [3:0] kk, input logic [3:0] dd);
        logic [3:0] res;
        if (r) return RV;
        if (!e) return cur;
        case (m)
            2'd0: begin
                for (int i = 0; i < 4; i++) begin
                    if (jj[i] && kk[i]) res[i] = ~cur[i];
                    else if (jj[i]) res[i] = 1'b1;
                    else if (kk[i]) res[i] = 1'b0;
                    else res[i] = cur[i];
                end
            end
`ifdef JK_SATURATE_EN
            2'd1: res = (cur == 4'd15) ? 4'd15 : 4'((cur + 1) % 16);
            2'd2: res = (cur == 4'd0) ? 4'd0 : 4'(cur - 1);
`else
            2'd1: res = 4'((cur + 1) % 16);
            2'd2: res = 4'((cur + 15) % 16);
`endif
            default: res = dd;
        endcase
        return res;
    endfunction

    function automatic logic model_tc(input logic [3:0] cur, input logic [1:0] m);
        if (m == 2'd1) return cur == 4'd15;
        if (m == 2'd2) return cur == 4'd0;
        return 1'b0;
    endfunction

    task automatic tick(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] jj, input logic [3:0] kk,
                        input logic [3:0] dd);
        rst = r; en = e; mode = m; j = jj; k = kk; d = dd;
        @(posedge clk);
        #1;
        mq = model_next(mq, r, e, m, jj, kk, dd);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 2'd1, 4'h0, 4'h0, 4'h0);
        if ({q, qb, tc} !== {4'b1010, 4'b0101, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: q/qb/tc got %b/%b/%b want 1010/0101/0", q, qb, tc);
        end
        n_cmp++;
    endtask

    task automatic test_direct_jk();
        logic [3:0] jt [5] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
        logic [3:0] kt [5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
        logic [3:0] ex [5] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'hF};
        tick(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 2'd0, jt[i], kt[i], 4'h0);
            if ({q, qb, tc} !== {ex[i], ~ex[i], 1'b0}) begin
                n_fail++;
                $display("FAIL direct_jk step %0d: q=%b tc=%b want q=%b tc=0",
                         i, q, tc, ex[i]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_count_up();
        logic [3:0] ex;
        tick(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
`ifdef JK_SATURATE_EN
            ex = (i >= 15) ? 4'hF : 4'(i);
`else
            ex = 4'(i % 16);
`endif
            if ({q, tc} !== {ex, ex == 4'hF}) begin
                n_fail++;
                $display("FAIL count_up edge %0d: q=%b tc=%b want q=%b tc=%b",
                         i, q, tc, ex, ex == 4'hF);
            end
            n_cmp++;
        end
    endtask

    task automatic test_load_down();
        logic [3:0] ex;
        tick(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b0011);
        if (q !== 4'b0011) begin
            n_fail++;
            $display("FAIL load: q=%b want 0011", q);
        end
        n_cmp++;
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'hC);
`ifdef JK_SATURATE_EN
            ex = (i >= 3) ? 4'h0 : 4'(3 - i);
`else
            ex = 4'((3 - i + 16) % 16);
`endif
            if ({q, tc} !== {ex, ex == 4'h0}) begin
                n_fail++;
                $display("FAIL count_down edge %0d: q=%b tc=%b want q=%b tc=%b",
                         i, q, tc, ex, ex == 4'h0);
            end
            n_cmp++;
        end
    endtask

    task automatic test_enable_hold();
        tick(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 2'd1, 4'hF, 4'hF, 4'hF);
            if (q !== 4'b0101) begin
                n_fail++;
                $display("FAIL en_hold edge %0d: q=%b want 0101", i, q);
            end
            n_cmp++;
        end
        tick(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
        if (q !== 4'b0110) begin
            n_fail++;
            $display("FAIL en_resume: q=%b want 0110", q);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_count();
        tick(1'b0, 1'b1, 2'd3, 4'h0, 4'h0, 4'b0111);
        tick(1'b1, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
        if (q !== RV) begin
            n_fail++;
            $display("FAIL mid_reset: q=%b want %b", q, RV);
        end
        n_cmp++;
        tick(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0);
        if (q !== 4'(RV + 1)) begin
            n_fail++;
            $display("FAIL mid_reset_resume: q=%b want %b", q, 4'(RV + 1));
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic r;
        logic e;
        logic [1:0] m;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = 2'($urandom_range(0, 3));
            tick(r, e, m, 4'($urandom), 4'($urandom), 4'($urandom));
            if ({q, qb, tc} !== {mq, ~mq, model_tc(mq, m)}) begin
                n_fail++;
                $display("FAIL random %0d: q/qb/tc=%b/%b/%b want %b/%b/%b",
                         i, q, qb, tc, mq, ~mq, model_tc(mq, m));
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd1;
        j = '0; k = '0; d = '0;
        mq = 4'h0;
        #1;
        test_reset();
        test_direct_jk();
        test_count_up();
        test_load_down();
        test_enable_hold();
        test_reset_mid_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
